// File: rtl/pipe_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : pipe_muldiv
// Description : Iterative multiply/divide unit with HI/LO result registers.
//               MULT/MULTU use a radix-2 shift-add multiplier. DIV/DIVU use a
//               radix-2 restoring divider. Both work on operand magnitudes,
//               take WIDTH cycles in CALC, and apply the sign in a single FIX
//               cycle. HI/LO can also be written directly (MTHI/MTLO) while
//               the unit is idle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH    operand width and width of HI and LO (8..64, even)
// Ports       : clk      rising-edge clock
//               rst_n    asynchronous active-low reset
//               start    launch request, sampled in IDLE
//               op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               src_a    multiplicand / dividend
//               src_b    multiplier / divisor
//               abort    cancels an in-flight operation, blocks a start
//               hi_we    MTHI write enable (idle only)
//               lo_we    MTLO write enable (idle only)
//               wr_data  MTHI/MTLO write data
//               busy     operation in flight
//               done     one-cycle pulse when HI/LO take a new result
//               hi, lo   result registers
// Macro       : PIPE_MULDIV_FAST_MUL_EN - when defined, MULT/MULTU complete
//               in the accepting cycle through a single-cycle multiplier.
// ============================================================================
module pipe_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_q, acc_d;    // product upper half / partial remainder
  logic [WIDTH-1:0]   low_q, low_d;    // multiplier bits / dividend -> quotient
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Launch decode and operand magnitudes
  logic               w_accept;
  logic               w_accept_iter;
  logic               w_accept_any;
  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  assign w_accept = (state_q == c_IDLE) && start && !abort;
  assign w_signed = !op[0];
  assign w_neg_a  = w_signed && src_a[WIDTH-1];
  assign w_neg_b  = w_signed && src_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -src_a : src_a;
  assign w_mag_b  = w_neg_b ? -src_b : src_b;

`ifdef PIPE_MULDIV_FAST_MUL_EN
  logic               w_accept_fast;
  logic [2*WIDTH-1:0] w_fast_raw;
  logic [2*WIDTH-1:0] w_fast_prod;

  // A fast multiply raises done in the following cycle; refusing one while
  // done is already high keeps done from pulsing two cycles in a row.
  assign w_accept_fast = w_accept && !op[1] && !done_q;
  assign w_accept_iter = w_accept && op[1];
  assign w_accept_any  = w_accept_iter || w_accept_fast;
  assign w_fast_raw    = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
  assign w_fast_prod   = (w_neg_a ^ w_neg_b) ? -w_fast_raw : w_fast_raw;
`else
  assign w_accept_iter = w_accept;
  assign w_accept_any  = w_accept;
`endif

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set. Then shift {carry, acc, low} right by one.
  logic [WIDTH:0]     w_mul_sum;
  assign w_mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The remainder stays below the divisor,
  // so the difference always fits in WIDTH bits.
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  assign w_div_sh   = {acc_q, low_q[WIDTH-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, opnd_q});
  assign w_div_diff = w_div_sh[WIDTH-1:0] - opnd_q;

  // Sign correction. The neg flags are only set for signed operations.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  assign w_prod     = {acc_q, low_q};
  assign w_prod_fix = (neg_a_q ^ neg_b_q) ? -w_prod : w_prod;
  assign w_quo_fix  = (neg_a_q ^ neg_b_q) ? -low_q : low_q;
  assign w_rem_fix  = neg_a_q ? -acc_q : acc_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_accept_iter) state_d = c_CALC;
      c_CALC:  begin
        if (abort)               state_d = c_IDLE;
        else if (cnt_q == '0)    state_d = c_FIX;
      end
      c_FIX:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q != c_IDLE);
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // ---------------- Datapath next values ----------------
  always_comb begin
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    low_d    = low_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (w_accept_iter) begin
          is_div_d = op[1];
          neg_a_d  = w_neg_a;
          neg_b_d  = w_neg_b;
          div0_d   = (src_b == '0);
          cnt_d    = c_LAST_CNT;
          acc_d    = '0;
          if (op[1]) begin
            opnd_d = w_mag_b;
            low_d  = w_mag_a;
          end else begin
            opnd_d = w_mag_a;
            low_d  = w_mag_b;
          end
        end
`ifdef PIPE_MULDIV_FAST_MUL_EN
        if (w_accept_fast) begin
          {hi_d, lo_d} = w_fast_prod;
          done_d       = 1'b1;
        end
`endif
        if (!w_accept_any) begin
          if (hi_we) hi_d = wr_data;
          if (lo_we) lo_d = wr_data;
        end
      end
      c_CALC: begin
        if (!abort) begin
          cnt_d = cnt_q - c_CNT_W'(1);
          if (is_div_q) begin
            acc_d = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], w_div_ge};
          end else begin
            acc_d = w_mul_sum[WIDTH:1];
            low_d = {w_mul_sum[0], low_q[WIDTH-1:1]};
          end
        end
      end
      c_FIX: begin
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // A zero divisor leaves the remainder equal to the dividend
            // magnitude, so only the quotient needs forcing.
            hi_d = w_rem_fix;
            lo_d = div0_q ? '1 : w_quo_fix;
          end else begin
            {hi_d, lo_d} = w_prod_fix;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_muldiv
// Description : Self-checking bench for pipe_muldiv (WIDTH=32). Directed
//               corner cases plus random operations. Results are checked
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_muldiv;

  localparam int c_W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [c_W-1:0] src_a = '0;
  logic [c_W-1:0] src_b = '0;
  logic           abort = 1'b0;
  logic           hi_we = 1'b0;
  logic           lo_we = 1'b0;
  logic [c_W-1:0] wr_data = '0;
  logic           busy;
  logic           done;
  logic [c_W-1:0] hi;
  logic [c_W-1:0] lo;

  int checks = 0;
  int failures = 0;

  pipe_muldiv #(.WIDTH(c_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .abort(abort),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: {hi, lo} from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib, q, m;
    logic [63:0]     r;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = 64'(ua * ub);
      2'b10: begin
        if (b == 0)                                  r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == '1)      r = {32'h0, 32'h8000_0000};
        else begin q = ia / ib; m = ia % ib;         r = {32'(m), 32'(q)}; end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Launch one operation from IDLE, scramble inputs after acceptance, poke
  // start and MTHI/MTLO while busy, and check the result and its timing.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic we_on_accept);
    logic [63:0] exp, prev;
    int          lat, exp_lat;
    logic        fast, held_bad;
    exp  = model(o, a, b);
    prev = {hi, lo};
    fast = 1'b0;
`ifdef PIPE_MULDIV_FAST_MUL_EN
    fast = !o[1];
`endif
    exp_lat = fast ? 0 : c_W + 1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    hi_we = we_on_accept; lo_we = we_on_accept; wr_data = $urandom;
    cycle();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    chk("busy_after_accept", 64'(busy), 64'(!fast));
    if (!fast) chk("hold_on_accept", {hi, lo}, prev);
    lat = 0; held_bad = 1'b0;
    while (!done && lat < 100) begin
      start   = (lat == 5);
      hi_we   = (lat == 7);
      lo_we   = (lat == 7);
      wr_data = $urandom;
      @(posedge clk); lat++; @(negedge clk);
      if (!done && {hi, lo} !== prev) held_bad = 1'b1;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", {hi, lo}, exp);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("hold_while_busy", 64'(held_bad), 64'd0);
    cycle();
    chk("done_single", 64'(done), 64'd0);
    chk("result_kept", {hi, lo}, exp);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (done) cnt++;
    end
  endtask

  initial begin
    logic [63:0] prev;
    int          nd;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // First start right after reset release; signed divide -7 / 2
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("mult_m1_m1", {hi, lo}, 64'h0000_0000_0000_0001);

    do_op(2'b11, 32'h1234_5678, 32'd0, 1'b0);
    chk("divu_by0", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    do_op(2'b10, 32'h8765_4321, 32'd0, 1'b1);
    chk("div_neg_by0", {hi, lo}, 64'h8765_4321_FFFF_FFFF);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);

    do_op(2'b00, 32'd3, 32'hFFFF_FFFC, 1'b0);
    chk("mult_3_m4", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wr_data = 32'hDEAD_BEEF; cycle(); hi_we = 1'b0;
    chk("mthi", {hi, lo}, {32'hDEAD_BEEF, 32'hFFFF_FFF4});
    lo_we = 1'b1; wr_data = 32'h0BAD_F00D; cycle(); lo_we = 1'b0;
    chk("mtlo", {hi, lo}, {32'hDEAD_BEEF, 32'h0BAD_F00D});
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h1357_9BDF; cycle();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h1357_9BDF, 32'h1357_9BDF});

    // Abort in CALC cycle 10, then MTHI the next cycle
    prev = {hi, lo};
    start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
    cycle();
    start = 1'b0;
    repeat (9) cycle();
    chk("busy_before_abort", 64'(busy), 64'd1);
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_no_write", {hi, lo}, prev);
    hi_we = 1'b1; wr_data = 32'hA5A5_A5A5; cycle(); hi_we = 1'b0;
    chk("mthi_after_abort", {hi, lo}, {32'hA5A5_A5A5, prev[31:0]});
    count_done(40, nd);
    chk("abort_no_done", 64'(nd), 64'd0);

    // Abort coincident with start in IDLE drops the start
    start = 1'b1; abort = 1'b1; op = 2'b11; src_a = 32'd50; src_b = 32'd5;
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 64'(busy), 64'd0);
    count_done(40, nd);
    chk("abort_start_no_done", 64'(nd), 64'd0);
    chk("abort_start_hilo", {hi, lo}, {32'hA5A5_A5A5, prev[31:0]});

    // Reset mid-CALC, with a start poked while busy beforehand
    start = 1'b1; op = 2'b11; src_a = 32'hFFFF_0000; src_b = 32'd3;
    cycle();
    start = 1'b0;
    chk("busy_calc", 64'(busy), 64'd1);
    start = 1'b1; op = 2'b01; cycle(); start = 1'b0;
    chk("start_ignored_busy", 64'(busy), 64'd1);
    repeat (4) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, nd);
    chk("rst_no_done", 64'(nd), 64'd0);
    chk("rst_hilo_after", {hi, lo}, 64'd0);

    // Random operations, with small and zero divisors mixed in
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(0, 9));
      if (i % 4 == 3) rb = -32'($urandom_range(1, 9));
      if (i % 5 == 2) ra = 32'($urandom_range(0, 200));
      do_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
